// File: rtl/setn_release_sequencer.sv
// setn_release_sequencer: drives active-low SETN to flop-bank domains,
// holds it, then releases selected domains one at a time.
module setn_release_sequencer #(
  parameter int N_DOM = 4,
  parameter int HOLD  = 8,
  parameter int GAP   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [N_DOM-1:0] MASK,
  output logic [N_DOM-1:0] SETN,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [N_DOM-1:0] sel;
  logic [N_DOM-1:0] sel_nx;
  logic [N_DOM-1:0] setn_nx;
  logic [N_DOM-1:0] pend;
  logic [N_DOM-1:0] low;
  logic             busy_nx;
  logic             done_nx;
  logic             tick;

  // Domains still held low, and the lowest of them (next to release).
  assign pend = sel & ~SETN;
  assign low  = pend & (~pend + N_DOM'(1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    setn_nx  = SETN;
    busy_nx  = BUSY;
    done_nx  = 1'b0;
    tick     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        setn_nx = '1;
        if (REQ) begin
          if (|MASK) begin
            sel_nx   = MASK;
            state_nx = S_ASSERT;
            cnt_nx   = '0;
            setn_nx  = ~MASK;
            busy_nx  = 1'b1;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      S_ASSERT:  tick = (cnt == HOLD_LAST);
      S_RELEASE: tick = (cnt == GAP_LAST);
      default:   state_nx = S_IDLE;
    endcase
    if (state != S_IDLE) begin
      cnt_nx = cnt + CW'(1);
      if (tick) begin
        cnt_nx   = '0;
        setn_nx  = SETN | low;
        state_nx = S_RELEASE;
        if (pend == low) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset forces a full all-domain sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_ASSERT;
      cnt   <= '0;
      sel   <= '1;
      SETN  <= '0;
      BUSY  <= 1'b1;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      SETN  <= setn_nx;
      BUSY  <= busy_nx;
      DONE  <= done_nx;
    end
  end

endmodule

// File: tb/tb_setn_release_sequencer.sv
// tb_setn_release_sequencer: directed checks of hold, staggered
// release, masking, ignored requests, reset abort and back-to-back.
module tb_setn_release_sequencer;

  localparam int HOLD = 8;
  localparam int GAP  = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ;
  logic [3:0] MASK;
  logic [3:0] SETN;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int passes = 0;

  setn_release_sequencer #(
    .N_DOM(4),
    .HOLD (HOLD),
    .GAP  (GAP)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .REQ (REQ),
    .MASK(MASK),
    .SETN(SETN),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int t,
                     input logic [5:0] exp);
    logic [5:0] obs;
    obs = {SETN, BUSY, DONE};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s t=%0d {SETN,BUSY,DONE} got %b want %b",
                tag, t, obs, exp);
  endtask

  // Expected {SETN,BUSY,DONE} t edges after entry for nonzero mask m.
  function automatic logic [5:0] expv(input logic [3:0] m, input int t);
    logic [3:0] s;
    int j;
    int last;
    s = 4'hF;
    j = 0;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (t < HOLD + j * GAP) s[i] = 1'b0;
        last = HOLD + j * GAP;
        j++;
      end
    end
    return {s, (t < last), (t == last)};
  endfunction

  initial begin
    RST  = 1'b1;
    REQ  = 1'b0;
    MASK = 4'h0;

    // Power-up reset: three edges high, then release.
    for (int e = 0; e < 3; e++) begin
      step();
      chk("rst_hold", e, 6'b0000_1_0);
    end
    RST = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      step();
      chk("pwrup", t, expv(4'hF, t));
    end

    // Masked request; MASK changes after acceptance.
    REQ  = 1'b1;
    MASK = 4'b0101;
    step();
    chk("mask_entry", 0, expv(4'b0101, 0));
    REQ  = 1'b0;
    MASK = 4'b1111;
    for (int t = 1; t <= 12; t++) begin
      step();
      chk("mask", t, expv(4'b0101, t));
    end

    // Empty mask: single DONE pulse, nothing else moves.
    REQ  = 1'b1;
    MASK = 4'b0000;
    step();
    chk("empty_done", 1, 6'b1111_0_1);
    REQ = 1'b0;
    step();
    chk("empty_after", 2, 6'b1111_0_0);

    // Requests while busy are ignored.
    REQ  = 1'b1;
    MASK = 4'b0011;
    step();
    chk("busy_entry", 0, expv(4'b0011, 0));
    for (int t = 1; t <= 13; t++) begin
      REQ  = (t == 3 || t == 9);
      MASK = REQ ? 4'b1111 : 4'b0000;
      step();
      chk("busy_req", t, expv(4'b0011, t));
    end
    REQ = 1'b0;

    // Reset on the edge where domain 1 would release.
    REQ  = 1'b1;
    MASK = 4'b1111;
    step();
    chk("abort_entry", 0, expv(4'hF, 0));
    REQ = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      step();
      chk("abort_pre", t, expv(4'hF, t));
    end
    RST = 1'b1;
    step();
    chk("abort_rst", 10, 6'b0000_1_0);
    RST = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      step();
      chk("abort_restart", t, expv(4'hF, t));
    end

    // Back-to-back: REQ held high, 9-cycle period.
    REQ  = 1'b1;
    MASK = 4'b1000;
    step();
    chk("b2b_entry", 0, expv(4'b1000, 0));
    for (int r = 0; r < 3; r++) begin
      for (int t = 1; t <= 9; t++) begin
        step();
        chk("b2b", t, (t == 9) ? expv(4'b1000, 0) : expv(4'b1000, t));
      end
    end
    REQ = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      step();
      chk("b2b_tail", t, expv(4'b1000, t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
